// File: rtl/cic_decimator.sv
// Two-stage CIC decimator: two integrators at the input rate, a dump every
// 2^ratio_log2 accepted samples, two combs and a gain-normalising shift.
// Differential delay is 1, so the combined response is a boxcar of length R,
// squared.
module cic_decimator #(
  parameter int INPUT_WIDTH    = 14,
  parameter int OUTPUT_WIDTH   = 14,
  parameter int MAX_RATIO_LOG2 = 10,
  parameter int RATIO_WIDTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [INPUT_WIDTH-1:0]  in_data,
  input  logic                           in_valid,
  input  logic [RATIO_WIDTH-1:0]         ratio_log2,
  output logic signed [OUTPUT_WIDTH-1:0] out_data,
  output logic                           out_valid
);

  localparam int ACC_WIDTH = INPUT_WIDTH + 2*MAX_RATIO_LOG2;
  localparam int CNT_W     = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;
  localparam int STAGES    = 3;
  localparam logic [RATIO_WIDTH-1:0] MAX_R = RATIO_WIDTH'(MAX_RATIO_LOG2);

  // frame state
  logic [CNT_W-1:0]       cnt;
  logic [RATIO_WIDTH-1:0] r_act, r_prev;
  logic [1:0]             wcnt;

  // integrators and combs; modular wrap is intentional
  logic signed [ACC_WIDTH-1:0] int1, int2, d1, d2, c1, c2;

  // pipeline: vld_pipe[0..2] mark a dump moving through the combs,
  // vld_pipe[STAGES] is the registered output strobe
  logic [STAGES:0]                        vld_pipe;
  logic [STAGES-1:0]                      ok_pipe;
  logic [STAGES-1:0][RATIO_WIDTH-1:0]     r_pipe;

  logic [RATIO_WIDTH-1:0]      r_clamp, r_cur;
  logic [CNT_W-1:0]            last_idx;
  logic                        dump;
  logic [1:0]                  wcnt_eff;
  logic signed [ACC_WIDTH-1:0] in_ext, int1_next, shifted;

  // frame bookkeeping: ratio for this frame is the live input on its first
  // sample, the latched copy afterwards, so R=1 frames still see the new value
  always_comb begin
    r_clamp   = (ratio_log2 > MAX_R) ? MAX_R : ratio_log2;
    r_cur     = (cnt == '0) ? r_clamp : r_act;
    last_idx  = ~({CNT_W{1'b1}} << r_cur);
    dump      = in_valid && (cnt == last_idx);
    in_ext    = {{(ACC_WIDTH-INPUT_WIDTH){in_data[INPUT_WIDTH-1]}}, in_data};
    int1_next = int1 + in_ext;
    // a ratio change restarts warm-up, and the changed dump itself is the
    // first of the two suppressed ones
    wcnt_eff  = (r_cur != r_prev) ? 2'd0 : wcnt;
    shifted   = c2 >>> {r_pipe[STAGES-1], 1'b0};
  end

  // integrators, sample counter, ratio latch and warm-up tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int1   <= '0;
      int2   <= '0;
      cnt    <= '0;
      r_act  <= '0;
      r_prev <= '0;
      wcnt   <= '0;
    end else if (in_valid) begin
      int1 <= int1_next;
      int2 <= int2 + int1_next;
      cnt  <= dump ? '0 : cnt + CNT_W'(1);
      if (cnt == '0) r_act <= r_clamp;
      if (dump) begin
        r_prev <= r_cur;
        wcnt   <= (wcnt_eff == 2'd2) ? 2'd2 : wcnt_eff + 2'd1;
      end
    end
  end

  // comb pipeline E1..E3; shift amount travels with the dumped frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      ok_pipe  <= '0;
      r_pipe   <= '0;
      d1       <= '0;
      d2       <= '0;
      c1       <= '0;
      c2       <= '0;
      out_data <= '0;
    end else begin
      vld_pipe[0]      <= dump;
      vld_pipe[1]      <= vld_pipe[0];
      vld_pipe[2]      <= vld_pipe[1];
      vld_pipe[STAGES] <= vld_pipe[2] && ok_pipe[2];
      ok_pipe          <= {ok_pipe[1:0], (wcnt_eff == 2'd2)};
      if (dump) r_pipe[0] <= r_cur;
      if (vld_pipe[0]) begin
        c1        <= int2 - d1;
        d1        <= int2;
        r_pipe[1] <= r_pipe[0];
      end
      if (vld_pipe[1]) begin
        c2        <= c1 - d2;
        d2        <= c1;
        r_pipe[2] <= r_pipe[1];
      end
      if (vld_pipe[2]) out_data <= shifted[OUTPUT_WIDTH-1:0];
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule
